// File: rtl/z80_io_responder.sv
// z80_io_responder: Z80 I/O target for page/ctrl/vector ports with a timer and UART IM2 interrupt source
module z80_io_responder #(
    parameter logic [7:0] PAGE_PORT = 8'h7F,
    parameter logic [7:0] CTRL_PORT = 8'h7E,
    parameter logic [7:0] VEC_PORT  = 8'h7D,
    parameter int         TICK_DIV  = 480000
) (
    input  logic       CLK_24MHz,
    input  logic       RES,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       WR,
    input  logic       M1,
    input  logic [7:0] A_LO,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic [4:0] PAGE,
    output logic       INT,
    input  logic       U_INT
);
    logic [1:0]  iorq_q, rd_q, wr_q, m1_q, uint_q, fill;
    logic        armed, io_wr_q, io_rd_q, inta_q;
    logic        en_tmr, en_uart, tmr_pend;
    logic [5:0]  vbase;
    logic [18:0] cnt;
    logic        io_wr, io_rd, inta, wr_edge, rd_edge, ack_edge;
    logic        tick, uart_pend, rd_hit, wr_page, wr_ctrl, wr_vec;
    logic [7:0]  rd_val;
    always_comb begin
        io_wr     = !iorq_q[1] && !wr_q[1] && m1_q[1];
        io_rd     = !iorq_q[1] && !rd_q[1] && m1_q[1];
        inta      = !iorq_q[1] && !m1_q[1];
        wr_edge   = armed && io_wr && !io_wr_q;
        rd_edge   = armed && io_rd && !io_rd_q && !io_wr;
        ack_edge  = armed && inta && !inta_q;
        wr_page   = wr_edge && (A_LO == PAGE_PORT);
        wr_ctrl   = wr_edge && (A_LO == CTRL_PORT);
        wr_vec    = wr_edge && (A_LO == VEC_PORT);
        tick      = cnt == 19'(TICK_DIV - 1);
        uart_pend = uint_q[1] && en_uart;
        rd_hit    = (A_LO == PAGE_PORT) || (A_LO == CTRL_PORT) || (A_LO == VEC_PORT);
        rd_val    = (A_LO == PAGE_PORT) ? {3'b000, PAGE} :
                    (A_LO == CTRL_PORT) ? {tmr_pend, uart_pend, 4'b0000, en_uart, en_tmr} :
                                          {vbase, 2'b00};
    end
    // armed stays low until IORQ is seen high with the synchronisers refilled,
    // so a strobe still held across reset release never counts as an access
    always_ff @(posedge CLK_24MHz or posedge RES)
        if (RES) begin
            iorq_q  <= 2'b11;
            rd_q    <= 2'b11;
            wr_q    <= 2'b11;
            m1_q    <= 2'b11;
            uint_q  <= 2'b00;
            fill    <= 2'b00;
            armed   <= 1'b0;
            io_wr_q <= 1'b0;
            io_rd_q <= 1'b0;
            inta_q  <= 1'b0;
        end else begin
            iorq_q  <= {iorq_q[0], IORQ};
            rd_q    <= {rd_q[0], RD};
            wr_q    <= {wr_q[0], WR};
            m1_q    <= {m1_q[0], M1};
            uint_q  <= {uint_q[0], U_INT};
            fill    <= {fill[0], 1'b1};
            armed   <= armed || (fill[1] && iorq_q[1]);
            io_wr_q <= io_wr;
            io_rd_q <= io_rd;
            inta_q  <= inta;
        end
    always_ff @(posedge CLK_24MHz or posedge RES)
        if (RES) begin
            PAGE     <= 5'd0;
            en_tmr   <= 1'b0;
            en_uart  <= 1'b0;
            tmr_pend <= 1'b0;
            vbase    <= 6'h3F;
            cnt      <= 19'd0;
            INT      <= 1'b1;
            D_OUT    <= 8'h00;
            D_OE     <= 1'b0;
        end else begin
            cnt      <= tick ? 19'd0 : cnt + 19'd1;
            PAGE     <= wr_page ? D_IN[4:0] : PAGE;
            en_tmr   <= wr_ctrl ? D_IN[0] : en_tmr;
            en_uart  <= wr_ctrl ? D_IN[1] : en_uart;
            vbase    <= wr_vec ? D_IN[7:2] : vbase;
            tmr_pend <= (tick && en_tmr) || (tmr_pend && !(wr_ctrl && D_IN[7]) && !ack_edge);
            INT      <= !(tmr_pend || uart_pend);
            if (rd_edge && rd_hit) begin
                D_OUT <= rd_val;
                D_OE  <= 1'b1;
            end else if (ack_edge) begin
                D_OUT <= {vbase, !tmr_pend, 1'b0};
                D_OE  <= 1'b1;
            end else if (io_wr || !(io_rd || inta)) begin
                D_OE  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_z80_io_responder.sv
// tb_z80_io_responder: randomized self-checking bench with a register-level reference model
module tb_z80_io_responder;
    localparam int DIV = 16;
    logic       clk = 1'b0;
    logic       RES = 1'b1;
    logic       IORQ = 1'b1, RD = 1'b1, WR = 1'b1, M1 = 1'b1, U_INT = 1'b0;
    logic [7:0] A_LO = 8'h00, D_IN = 8'h00;
    logic [7:0] D_OUT;
    logic       D_OE, INT;
    logic [4:0] PAGE;
    int         vecs = 0, errs = 0, cyc = 0;
    logic [4:0] page_m = 5'd0;
    logic [5:0] vbase_m = 6'h3F;
    logic       en_tmr_m = 1'b0, en_uart_m = 1'b0;

    z80_io_responder #(.TICK_DIV(DIV)) dut (
        .CLK_24MHz(clk), .RES(RES), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1),
        .A_LO(A_LO), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .PAGE(PAGE),
        .INT(INT), .U_INT(U_INT)
    );

    always #5 clk = ~clk;
    always @(posedge clk or posedge RES) cyc <= RES ? 0 : cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align(input int k);
        for (int i = 0; i < 2 * DIV && (cyc % DIV) != k; i++) nclk(1);
    endtask

    task automatic bus_out(input logic [7:0] a, input logic [7:0] d, input int hold);
        A_LO = a; D_IN = d; IORQ = 1'b0; WR = 1'b0;
        nclk(hold);
        IORQ = 1'b1; WR = 1'b1;
        nclk(3);
    endtask

    task automatic bus_in(input logic [7:0] a, output logic [7:0] dat,
                          output logic oe_early, output logic oe, output logic oe_late);
        A_LO = a; IORQ = 1'b0; RD = 1'b0;
        nclk(2); oe_early = D_OE;
        nclk(1); oe = D_OE; dat = D_OUT;
        nclk(2);
        IORQ = 1'b1; RD = 1'b1;
        nclk(3); oe_late = D_OE;
        nclk(1);
    endtask

    task automatic bus_ack(output logic [7:0] dat, output logic oe);
        IORQ = 1'b0; M1 = 1'b0;
        nclk(3); oe = D_OE; dat = D_OUT;
        nclk(2);
        IORQ = 1'b1; M1 = 1'b1;
        nclk(3);
    endtask

    task automatic test_reset;
        nclk(3);
        vecs++; if (PAGE !== 5'd0) begin errs++; $display("FAIL reset_page: got %h required 00", PAGE); end
        vecs++; if (D_OE !== 1'b0) begin errs++; $display("FAIL reset_oe: got %b required 0", D_OE); end
        vecs++; if (INT !== 1'b1) begin errs++; $display("FAIL reset_int: got %b required 1", INT); end
        vecs++; if (D_OUT !== 8'h00) begin errs++; $display("FAIL reset_dout: got %h required 00", D_OUT); end
        RES = 1'b0;
        nclk(4);
        vecs++; if (PAGE !== 5'd0 || INT !== 1'b1) begin errs++; $display("FAIL post_reset: got page %h int %b required 00 1", PAGE, INT); end
    endtask

    task automatic test_write_page;
        logic saw_oe = 1'b0;
        A_LO = 8'h7F; D_IN = 8'h13; IORQ = 1'b0; WR = 1'b0;
        nclk(2);
        vecs++; if (PAGE !== page_m) begin errs++; $display("FAIL page_early: got %h required %h", PAGE, page_m); end
        nclk(1);
        page_m = 5'h13;
        vecs++; if (PAGE !== page_m) begin errs++; $display("FAIL page_latency: got %h required %h", PAGE, page_m); end
        D_IN = 8'h0C;
        for (int i = 0; i < 37; i++) begin nclk(1); saw_oe |= D_OE; end
        vecs++; if (saw_oe !== 1'b0) begin errs++; $display("FAIL write_oe: got %b required 0", saw_oe); end
        vecs++; if (PAGE !== page_m) begin errs++; $display("FAIL single_write: got %h required %h", PAGE, page_m); end
        IORQ = 1'b1; WR = 1'b1;
        nclk(3);
    endtask

    task automatic test_random_regs;
        logic [7:0] a, d, dat, exp_v;
        logic       u, e0, e1, e2;
        for (int it = 0; it < 24; it++) begin
            u = 1'($urandom_range(0, 1));
            U_INT = u;
            case ($urandom_range(0, 3))
                0: a = 8'h7F;
                1: a = 8'h7E;
                2: a = 8'h7D;
                default: begin a = 8'($urandom); if (a >= 8'h7D && a <= 8'h7F) a = 8'h10; end
            endcase
            d = 8'($urandom);
            if (a == 8'h7E) d[0] = 1'b0;
            bus_out(a, d, 3 + $urandom_range(0, 3));
            if (a == 8'h7F) page_m = d[4:0];
            if (a == 8'h7E) begin en_tmr_m = d[0]; en_uart_m = d[1]; end
            if (a == 8'h7D) vbase_m = d[7:2];
            case ($urandom_range(0, 2))
                0: a = 8'h7F;
                1: a = 8'h7E;
                default: a = 8'h7D;
            endcase
            exp_v = (a == 8'h7F) ? {3'b000, page_m} :
                    (a == 8'h7E) ? {1'b0, u & en_uart_m, 4'b0000, en_uart_m, en_tmr_m} :
                                   {vbase_m, 2'b00};
            bus_in(a, dat, e0, e1, e2);
            vecs++; if (e0 !== 1'b0) begin errs++; $display("FAIL rd_oe_early[%0d]: got %b required 0", it, e0); end
            vecs++; if (e1 !== 1'b1) begin errs++; $display("FAIL rd_oe[%0d]: got %b required 1", it, e1); end
            vecs++; if (dat !== exp_v) begin errs++; $display("FAIL rd_data[%0d] port %h: got %h required %h", it, a, dat, exp_v); end
            vecs++; if (e2 !== 1'b0) begin errs++; $display("FAIL rd_oe_late[%0d]: got %b required 0", it, e2); end
            vecs++; if (INT !== !(u & en_uart_m)) begin errs++; $display("FAIL rd_int[%0d]: got %b required %b", it, INT, !(u & en_uart_m)); end
        end
    endtask

    task automatic test_read_vec;
        logic [7:0] dat;
        logic       e0, e1, e2;
        bus_out(8'h7D, 8'hA5, 3);
        vbase_m = 6'h29;
        bus_in(8'h7D, dat, e0, e1, e2);
        vecs++; if ({e0, e1, e2} !== 3'b010) begin errs++; $display("FAIL vec_oe_timing: got %b required 010", {e0, e1, e2}); end
        vecs++; if (dat !== 8'hA4) begin errs++; $display("FAIL vec_read: got %h required a4", dat); end
        bus_in(8'h7C, dat, e0, e1, e2);
        vecs++; if ({e0, e1, e2} !== 3'b000) begin errs++; $display("FAIL unmatched_oe: got %b required 000", {e0, e1, e2}); end
        U_INT = 1'b0;
        bus_out(8'h7E, 8'h80, 3);
        en_tmr_m = 1'b0; en_uart_m = 1'b0;
    endtask

    task automatic test_timer;
        int  w, t, seen = -1;
        logic [7:0] held;
        align(4);
        w = cyc + 3;
        bus_out(8'h7E, 8'h01, 3);
        en_tmr_m = 1'b1;
        t = (w / DIV + 1) * DIV;
        for (int i = 0; i < 4 * DIV && seen < 0; i++) begin
            if (INT === 1'b0) seen = cyc; else nclk(1);
        end
        vecs++; if (seen !== t + 1) begin errs++; $display("FAIL timer_int_cycle: got %0d required %0d", seen, t + 1); end
        IORQ = 1'b0; M1 = 1'b0;
        nclk(3);
        vecs++; if (D_OE !== 1'b1) begin errs++; $display("FAIL ack_oe: got %b required 1", D_OE); end
        vecs++; if (D_OUT !== {vbase_m, 2'b00}) begin errs++; $display("FAIL ack_timer_vec: got %h required %h", D_OUT, {vbase_m, 2'b00}); end
        vecs++; if (INT !== 1'b0) begin errs++; $display("FAIL ack_int_still_low: got %b required 0", INT); end
        held = D_OUT;
        nclk(1);
        vecs++; if (INT !== 1'b1) begin errs++; $display("FAIL ack_int_release: got %b required 1", INT); end
        nclk(2);
        vecs++; if (D_OE !== 1'b1 || D_OUT !== held) begin errs++; $display("FAIL ack_hold: got oe %b data %h required 1 %h", D_OE, D_OUT, held); end
        IORQ = 1'b1; M1 = 1'b1;
        nclk(3);
        vecs++; if (D_OE !== 1'b0) begin errs++; $display("FAIL ack_oe_drop: got %b required 0", D_OE); end
    endtask

    task automatic test_priority;
        int  w, t;
        logic [7:0] dat;
        logic       oe;
        U_INT = 1'b1;
        align(4);
        w = cyc + 3;
        bus_out(8'h7E, 8'h03, 3);
        en_tmr_m = 1'b1; en_uart_m = 1'b1;
        t = (w / DIV + 1) * DIV;
        for (int i = 0; i < 4 * DIV && cyc != t + 2; i++) nclk(1);
        bus_ack(dat, oe);
        vecs++; if (oe !== 1'b1 || dat !== {vbase_m, 2'b00}) begin errs++; $display("FAIL prio_first: got oe %b vec %h required 1 %h", oe, dat, {vbase_m, 2'b00}); end
        bus_ack(dat, oe);
        vecs++; if (oe !== 1'b1 || dat !== {vbase_m, 2'b10}) begin errs++; $display("FAIL prio_second: got oe %b vec %h required 1 %h", oe, dat, {vbase_m, 2'b10}); end
        vecs++; if (INT !== 1'b0) begin errs++; $display("FAIL prio_int_low: got %b required 0", INT); end
        align(4);
        bus_out(8'h7E, 8'h82, 3);
        en_tmr_m = 1'b0;
        nclk(2);
        vecs++; if (INT !== 1'b0) begin errs++; $display("FAIL uart_level_int: got %b required 0", INT); end
        U_INT = 1'b0;
        nclk(4);
        vecs++; if (INT !== 1'b1) begin errs++; $display("FAIL uart_int_release: got %b required 1", INT); end
        bus_ack(dat, oe);
        vecs++; if (oe !== 1'b1 || dat !== {vbase_m, 2'b10}) begin errs++; $display("FAIL ack_none: got oe %b vec %h required 1 %h", oe, dat, {vbase_m, 2'b10}); end
    endtask

    task automatic test_clear_collision;
        logic [7:0] dat;
        logic       e0, e1, e2;
        align(4);
        bus_out(8'h7E, 8'h01, 3);
        align(DIV - 3);
        bus_out(8'h7E, 8'h81, 3);
        bus_in(8'h7E, dat, e0, e1, e2);
        vecs++; if (dat !== 8'h81) begin errs++; $display("FAIL clear_vs_tick: got %h required 81", dat); end
        align(4);
        bus_out(8'h7E, 8'h80, 3);
        bus_in(8'h7E, dat, e0, e1, e2);
        vecs++; if (dat !== 8'h00) begin errs++; $display("FAIL clear_pend: got %h required 00", dat); end
        en_tmr_m = 1'b0; en_uart_m = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d, dat;
        logic       e0, e1, e2;
        A_LO = 8'h7F; D_IN = 8'h1B; IORQ = 1'b0; WR = 1'b0;
        nclk(4);
        vecs++; if (PAGE !== 5'h1B) begin errs++; $display("FAIL mid_pre: got %h required 1b", PAGE); end
        #2 RES = 1'b1;
        #1;
        vecs++; if (PAGE !== 5'd0 || INT !== 1'b1 || D_OE !== 1'b0) begin errs++; $display("FAIL mid_async: got page %h int %b oe %b required 00 1 0", PAGE, INT, D_OE); end
        nclk(2);
        RES = 1'b0;
        nclk(10);
        vecs++; if (PAGE !== 5'd0) begin errs++; $display("FAIL held_strobe: got %h required 00", PAGE); end
        IORQ = 1'b1; WR = 1'b1;
        nclk(4);
        page_m = 5'd0; vbase_m = 6'h3F;
        d = 8'($urandom) | 8'h01;
        bus_out(8'h7F, d, 3);
        page_m = d[4:0];
        vecs++; if (PAGE !== page_m) begin errs++; $display("FAIL next_out: got %h required %h", PAGE, page_m); end
        bus_in(8'h7D, dat, e0, e1, e2);
        vecs++; if (dat !== 8'hFC || e1 !== 1'b1) begin errs++; $display("FAIL vbase_reset: got %h oe %b required fc 1", dat, e1); end
    endtask

    initial begin
        test_reset;
        test_write_page;
        test_random_regs;
        test_read_vec;
        test_timer;
        test_priority;
        test_clear_collision;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
